// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch unit.
// Holds the NOP encoding, PC geometry and the queue entry layout.
package if_prefetch_pkg;

  localparam int unsigned PC_W          = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  localparam logic [PC_W-1:0] PC_STEP  = 32'd4;
  localparam logic [31:0]     INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } pf_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pf_fifo.sv
// Power-of-two circular FIFO with occupancy count and synchronous flush.
// Read data is the head entry, presented combinationally from storage.
module pf_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free because Depth is a power of two.
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: fetches sequentially from fetch_pc into a small queue
// and offers the head to the core; a redirect flushes and restarts fetching.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_ce_o,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic        out_valid_o,
  output logic [31:0] out_inst_o,
  output logic [31:0] out_pc_o,
  input  logic        out_ready_i
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count;
  logic            push, pop, valid;
  pf_entry_t       head, wr_entry;

  assign valid = (count != '0);
  assign pop   = valid & out_ready_i & ~redirect_i;
  // Gating with rst_n keeps the memory idle while reset is held.
  assign push  = rst_n & ~redirect_i & ((count < Full) | pop);

  assign wr_entry.pc   = fetch_pc_q;
  assign wr_entry.inst = inst_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  pf_fifo #(
    .Width ($bits(pf_entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign inst_ce_o   = push;
  assign inst_addr_o = fetch_pc_q;
  assign out_valid_o = valid;
  assign out_inst_o  = valid ? head.inst : INST_NOP;
  assign out_pc_o    = valid ? head.pc : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed and randomised checks of the prefetch queue against hand-derived
// expectations and a small queue model.
module tb_if_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_ce_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic        out_valid_o;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] mem_key = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory word at address A is A ^ mem_key.
  assign inst_i = inst_addr_o ^ mem_key;

  if_prefetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_ce_o     (inst_ce_o),
    .inst_addr_o   (inst_addr_o),
    .inst_i        (inst_i),
    .out_valid_o   (out_valid_o),
    .out_inst_o    (out_inst_o),
    .out_pc_o      (out_pc_o),
    .out_ready_i   (out_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic apply_reset(input logic rdy);
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    out_ready_i = rdy;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    out_ready_i = 1'b1;
    #2;
    total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL rst_ce got=%b want=0", inst_ce_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid_o); end
    total++; if (out_inst_o !== NOP) begin bad++; $display("FAIL rst_inst got=%h want=%h", out_inst_o, NOP); end
    total++; if (out_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", out_pc_o); end
    total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", inst_addr_o); end
  endtask

  task automatic test_stream();
    mem_key = '0;
    apply_reset(1'b1);
    total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL stream_c1_ce got=%b want=1", inst_ce_o); end
    total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL stream_c1_addr got=%h want=0", inst_addr_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL stream_c1_valid got=%b want=0", out_valid_o); end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b want=1", k, out_valid_o); end
      total++; if (out_pc_o !== 32'(4 * k)) begin bad++; $display("FAIL stream_pc k=%0d got=%h want=%h", k, out_pc_o, 32'(4 * k)); end
      total++; if (out_inst_o !== 32'(4 * k)) begin bad++; $display("FAIL stream_inst k=%0d got=%h want=%h", k, out_inst_o, 32'(4 * k)); end
      total++; if (inst_addr_o !== 32'(4 * k + 4)) begin bad++; $display("FAIL stream_addr k=%0d got=%h want=%h", k, inst_addr_o, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_stall();
    logic        exp_ce;
    logic [31:0] exp_addr;
    mem_key = '0;
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      exp_ce   = (i < 4);
      exp_addr = (i < 4) ? 32'(4 * i) : 32'h10;
      total++; if (inst_ce_o !== exp_ce) begin bad++; $display("FAIL stall_ce i=%0d got=%b want=%b", i, inst_ce_o, exp_ce); end
      total++; if (inst_addr_o !== exp_addr) begin bad++; $display("FAIL stall_addr i=%0d got=%h want=%h", i, inst_addr_o, exp_addr); end
      total++; if (out_valid_o !== (i > 0)) begin bad++; $display("FAIL stall_valid i=%0d got=%b want=%b", i, out_valid_o, (i > 0)); end
    end
    tick();
    out_ready_i = 1'b1;
    #1;
    total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL stall_release_ce got=%b want=1", inst_ce_o); end
    total++; if (inst_addr_o !== 32'h10) begin bad++; $display("FAIL stall_release_addr got=%h want=10", inst_addr_o); end
    total++; if (out_pc_o !== 32'h0) begin bad++; $display("FAIL stall_release_pc got=%h want=0", out_pc_o); end
    tick();
    total++; if (out_pc_o !== 32'h4) begin bad++; $display("FAIL stall_next_pc got=%h want=4", out_pc_o); end
    total++; if (inst_addr_o !== 32'h14) begin bad++; $display("FAIL stall_next_addr got=%h want=14", inst_addr_o); end
    total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL stall_next_ce got=%b want=1", inst_ce_o); end
  endtask

  task automatic test_redirect();
    mem_key = '0;
    apply_reset(1'b0);
    repeat (4) tick();
    out_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    #1;
    total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL redir_ce got=%b want=0", inst_ce_o); end
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL redir_full_valid got=%b want=1", out_valid_o); end
    tick();
    redirect_i = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL redir_flush_valid got=%b want=0", out_valid_o); end
    total++; if (inst_addr_o !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h want=100", inst_addr_o); end
    total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL redir_refetch_ce got=%b want=1", inst_ce_o); end
    tick();
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL redir_head_valid got=%b want=1", out_valid_o); end
    total++; if (out_pc_o !== 32'h100) begin bad++; $display("FAIL redir_head_pc got=%h want=100", out_pc_o); end
    total++; if (out_inst_o !== 32'h100) begin bad++; $display("FAIL redir_head_inst got=%h want=100", out_inst_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    mem_key = '0;
    out_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFB;
    tick();
    redirect_i = 1'b0;
    #1;
    total++; if (inst_addr_o !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_addr got=%h want=fffffff8", inst_addr_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_pc_o !== exp_pc[i]) begin bad++; $display("FAIL wrap_pc i=%0d got=%h want=%h", i, out_pc_o, exp_pc[i]); end
      total++; if (out_inst_o !== exp_pc[i]) begin bad++; $display("FAIL wrap_inst i=%0d got=%h want=%h", i, out_inst_o, exp_pc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    mem_key = '0;
    apply_reset(1'b0);
    repeat (3) tick();
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", out_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid_o); end
    total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL mid_ce got=%b want=0", inst_ce_o); end
    total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL mid_addr got=%h want=0", inst_addr_o); end
    total++; if (out_inst_o !== NOP) begin bad++; $display("FAIL mid_inst got=%h want=%h", out_inst_o, NOP); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL mid_restart_ce got=%b want=1", inst_ce_o); end
    total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL mid_restart_addr got=%h want=0", inst_addr_o); end
    tick();
    total++; if (out_pc_o !== 32'h0 || out_valid_o !== 1'b1) begin bad++; $display("FAIL mid_restart_head got=%b/%h want=1/0", out_valid_o, out_pc_o); end
  endtask

  task automatic test_stress();
    logic [31:0] q [$];
    logic [31:0] mpc;
    logic        mpop, mpush;
    logic [97:0] got, exp;
    mem_key = 32'hA5A5_0000;
    apply_reset(1'b1);
    mpc = 32'h0;
    for (int c = 0; c < 400; c++) begin
      out_ready_i   = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 15) == 0);
      redirect_pc_i = $urandom;
      #1;
      mpop  = (q.size() != 0) && out_ready_i && !redirect_i;
      mpush = !redirect_i && ((q.size() < 4) || mpop);
      exp = {(q.size() != 0), mpush, mpc,
             (q.size() != 0) ? q[0] : 32'h0,
             (q.size() != 0) ? (q[0] ^ mem_key) : NOP};
      got = {out_valid_o, inst_ce_o, inst_addr_o, out_pc_o, out_inst_o};
      total++; if (got !== exp) begin bad++; $display("FAIL stress c=%0d got=%h want=%h", c, got, exp); end
      total++; if (dut.u_fifo.count_o > 4) begin bad++; $display("FAIL stress_count c=%0d got=%0d want<=4", c, dut.u_fifo.count_o); end
      total++; if (dut.u_fifo.pop_i && dut.u_fifo.count_o == 0) begin bad++; $display("FAIL stress_empty_pop c=%0d got=1 want=0", c); end
      if (redirect_i) begin
        q.delete();
        mpc = {redirect_pc_i[31:2], 2'b00};
      end else begin
        if (mpop) void'(q.pop_front());
        if (mpush) begin
          q.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
      tick();
    end
    redirect_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
